wb_trace_buf: RTL and testbench

//  Consumer end of the pipeline's architectural-write trace. Captures GRF writebacks (W stage) and DM

---
 rtl/wb_trace_buf_pkg.sv | 35 +++
 rtl/wb_trace_buf_if.sv | 40 ++++
 rtl/wb_trace_buf_ram.sv | 26 ++
 rtl/wb_trace_buf.sv | 102 ++++++++++
 tb/tb_wb_trace_buf.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_buf_pkg.sv
// Shared definitions for the architectural-write trace: entry kinds, entry width and field offsets.
// An entry is packed MSB..LSB as {kind, pc, addr, data}.
package mips_trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int TRACE_DATA_W = 32;

    function automatic int entry_w(input int dw);
        return 1 + 3 * dw;
    endfunction

    function automatic int kind_bit(input int dw);
        return 3 * dw;
    endfunction

    function automatic int pc_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    localparam int ENTRY_W = entry_w(TRACE_DATA_W);

    typedef struct packed {
        logic                    kind;
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_buf_if.sv
// Trace buffer bundle: W/M-stage event inputs plus the drained valid/ready output port.
// master = pipeline/checker side, slave = the trace buffer itself.
interface wb_trace_buf_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              grf_we;
    logic [DATA_W-1:0] grf_pc;
    logic [4:0]        grf_addr;
    logic [DATA_W-1:0] grf_wdata;
    logic              dm_we;
    logic [DATA_W-1:0] dm_pc;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport master (
        output grf_we, grf_pc, grf_addr, grf_wdata,
        output dm_we, dm_pc, dm_addr, dm_wdata,
        output out_ready,
        input  out_valid, out_kind, out_pc, out_addr, out_data, level, overflow
    );

    modport slave (
        input  grf_we, grf_pc, grf_addr, grf_wdata,
        input  dm_we, dm_pc, dm_addr, dm_wdata,
        input  out_ready,
        output out_valid, out_kind, out_pc, out_addr, out_data, level, overflow
    );

endinterface

// File: rtl/wb_trace_buf_ram.sv
// Trace entry storage: two ordered write ports (port 1 wins on a shared address), one async read.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 97
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] wa0,
    input  logic [W-1:0]             wd0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] wa1,
    input  logic [W-1:0]             wd1,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [W-1:0]             rd
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we0) mem_q[wa0] <= wd0;
        if (we1) mem_q[wa1] <= wd1;
    end

    assign rd = mem_q[ra];

endmodule

// File: rtl/wb_trace_buf.sv
// Architectural-write trace buffer: GRF writebacks and DM stores into an in-order FIFO, drained 1/cycle.
// Define TRACE_DISPLAY_EN to print every drained entry and the first overflow.
module wb_trace_buf
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    wb_trace_buf_if.slave tif
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int EW       = entry_w(DATA_W);
    localparam int KIND_BIT = kind_bit(DATA_W);
    localparam int PC_LSB   = pc_lsb(DATA_W);
    localparam int ADDR_LSB = addr_lsb(DATA_W);

    logic [CW-1:0] count_q, count_d, free, remain;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr1;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] head_q, head_d, grf_entry, dm_entry, ram_rd;
    logic          pop, grf_acc, dm_acc, drop;

    assign grf_entry = {KIND_GRF, tif.grf_pc, DATA_W'(tif.grf_addr), tif.grf_wdata};
    assign dm_entry  = {KIND_DM, tif.dm_pc, tif.dm_addr, tif.dm_wdata};

    // GRF (older W-stage instruction) claims a free slot before the DM store.
    always_comb begin
        pop      = (count_q != '0) && tif.out_ready;
        free     = CW'(DEPTH) - count_q + CW'(pop);
        grf_acc  = tif.grf_we && (free != '0);
        dm_acc   = tif.dm_we && (free > CW'(grf_acc));
        drop     = (tif.grf_we && !grf_acc) || (tif.dm_we && !dm_acc);
        wr_addr1 = wr_ptr_q + AW'(grf_acc);
        wr_ptr_d = wr_addr1 + AW'(dm_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        remain   = count_q - CW'(pop);
        count_d  = remain + CW'(grf_acc) + CW'(dm_acc);
        ovf_d    = ovf_q | drop;
    end

    // Head register preloads the next head; when the FIFO drains to empty the oldest push bypasses the RAM.
    always_comb begin
        head_d = head_q;
        if (count_d != '0)
            head_d = (remain != '0) ? ram_rd : (grf_acc ? grf_entry : dm_entry);
    end

    trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk (clk),
        .we0 (grf_acc),
        .wa0 (wr_ptr_q),
        .wd0 (grf_entry),
        .we1 (dm_acc),
        .wa1 (wr_addr1),
        .wd1 (dm_entry),
        .ra  (rd_ptr_d),
        .rd  (ram_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    assign tif.out_valid = (count_q != '0);
    assign tif.out_kind  = head_q[KIND_BIT];
    assign tif.out_pc    = head_q[PC_LSB +: DATA_W];
    assign tif.out_addr  = head_q[ADDR_LSB +: DATA_W];
    assign tif.out_data  = head_q[DATA_W-1:0];
    assign tif.level     = count_q;
    assign tif.overflow  = ovf_q;

`ifdef TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (reset && pop) begin
            if (tif.out_kind == KIND_GRF)
                $display("@%h: $%d <= %h", tif.out_pc, tif.out_addr[4:0], tif.out_data);
            else
                $display("@%h: *%h <= %h", tif.out_pc, tif.out_addr, tif.out_data);
        end
        if (reset && drop && !ovf_q) $display("TRACE OVERFLOW");
    end
`else
    // Quiet build: the trace is observable only through the output port.
`endif

endmodule

// File: tb/tb_wb_trace_buf.sv
// Scoreboard bench for wb_trace_buf: a queue-based occupancy model feeds expected entries,
// a negedge monitor compares the presented head, level, valid and overflow.
module tb_wb_trace_buf;
    import mips_trace_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_trace_buf_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) tif ();

    wb_trace_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif)
    );

    trace_entry_t exp_q[$];
    int  m_cnt     = 0;
    int  exp_level = 0;
    bit  m_ovf     = 0;
    bit  exp_ovf   = 0;
    bit  chk_en    = 0;
    int  n_checks  = 0;
    int  n_pass    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: inputs change at posedge+1, so negedge sees the values the next edge will act on.
    always @(negedge clk) begin
        if (reset && chk_en) begin
            chk("level", 32'(tif.level), 32'(exp_level));
            chk("out_valid", 32'(tif.out_valid), 32'(exp_level != 0));
            chk("overflow", 32'(tif.overflow), 32'(exp_ovf));
            if (tif.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL head: out_valid with empty scoreboard at %0t", $time);
                end else begin
                    chk("head_kind", 32'(tif.out_kind), 32'(exp_q[0].kind));
                    chk("head_pc", tif.out_pc, exp_q[0].pc);
                    chk("head_addr", tif.out_addr, exp_q[0].addr);
                    chk("head_data", tif.out_data, exp_q[0].data);
                    if (tif.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_idle();
        tif.grf_we = 0; tif.grf_pc = '0; tif.grf_addr = '0; tif.grf_wdata = '0;
        tif.dm_we  = 0; tif.dm_pc  = '0; tif.dm_addr  = '0; tif.dm_wdata  = '0;
        tif.out_ready = 0;
    endtask

    // Drive one cycle of events and advance the reference model across the coming edge.
    task automatic step(input bit gw, input logic [31:0] gpc, input logic [4:0] ga, input logic [31:0] gd,
                        input bit dw, input logic [31:0] dpc, input logic [31:0] da, input logic [31:0] dd,
                        input bit rdy);
        int free, acc;
        bit pop, drop;
        trace_entry_t e;
        tif.grf_we = gw; tif.grf_pc = gpc; tif.grf_addr = ga; tif.grf_wdata = gd;
        tif.dm_we  = dw; tif.dm_pc  = dpc; tif.dm_addr  = da; tif.dm_wdata  = dd;
        tif.out_ready = rdy;
        exp_level = m_cnt;
        exp_ovf   = m_ovf;
        pop  = (m_cnt != 0) && rdy;
        free = DEPTH - m_cnt + int'(pop);
        acc  = 0;
        drop = 0;
        if (gw) begin
            if (free > 0) begin
                e.kind = KIND_GRF; e.pc = gpc; e.addr = 32'(ga); e.data = gd;
                exp_q.push_back(e);
                free--; acc++;
            end else drop = 1;
        end
        if (dw) begin
            if (free > 0) begin
                e.kind = KIND_DM; e.pc = dpc; e.addr = da; e.data = dd;
                exp_q.push_back(e);
                free--; acc++;
            end else drop = 1;
        end
        m_cnt = m_cnt + acc - int'(pop);
        if (drop) m_ovf = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, '0, '0, '0, 0, '0, '0, '0, rdy);
    endtask

    task automatic step_rand(input bit gw, input bit dw, input bit rdy);
        step(gw, $urandom, 5'($urandom), $urandom, dw, $urandom, $urandom, $urandom, rdy);
    endtask

    initial begin
        int pushed;
        set_idle();
        #1 reset = 0;
        #11;
        chk("rst_valid", 32'(tif.out_valid), 0);
        chk("rst_level", 32'(tif.level), 0);
        chk("rst_overflow", 32'(tif.overflow), 0);
        chk("rst_kind", 32'(tif.out_kind), 0);
        chk("rst_pc", tif.out_pc, 0);
        chk("rst_addr", tif.out_addr, 0);
        chk("rst_data", tif.out_data, 0);
        @(posedge clk); #1;
        reset  = 1;
        chk_en = 1;

        // Single GRF write, drained immediately.
        idle(1); idle(1);
        step(1, 32'h3000, 5'd8, 32'h1234, 0, '0, '0, '0, 1);
        chk("t1_valid_next", 32'(tif.out_valid), 1);
        idle(1); idle(1);

        // GRF and DM in the same cycle: GRF must drain first.
        step(1, 32'h3004, 5'd3, 32'hdeadbeef, 1, 32'h3008, 32'h10, 32'hff, 1);
        chk("t2_level", 32'(tif.level), 2);
        idle(1); idle(1); idle(1);

        // Fill with the consumer stalled, then one more push overflows.
        for (int i = 0; i < DEPTH; i++) step_rand(1, 0, 0);
        chk("t3_full_level", 32'(tif.level), DEPTH);
        chk("t3_no_ovf", 32'(tif.overflow), 0);
        step_rand(1, 0, 0);
        chk("t3_ovf_level", 32'(tif.level), DEPTH);
        chk("t3_ovf", 32'(tif.overflow), 1);

        // Full with pop and two pushes: GRF takes the freed slot, DM is dropped.
        step_rand(1, 1, 1);
        chk("t4_level", 32'(tif.level), DEPTH);
        idle(0);
        for (int i = 0; i < DEPTH + 4; i++) idle(1);
        chk("t4_drained", 32'(tif.level), 0);

        // Randomized traffic with a random consumer.
        pushed = 0;
        for (int c = 0; c < 200; c++) begin
            bit g, d;
            g = (pushed < 20) && ($urandom_range(0, 1) == 1);
            d = (pushed + int'(g) < 20) && ($urandom_range(0, 2) == 0);
            step_rand(g, d, $urandom_range(0, 1) == 1);
            pushed += int'(g) + int'(d);
        end
        for (int i = 0; i < DEPTH + 8; i++) idle(1);
        chk("t5_sb_empty", 32'(exp_q.size()), 0);
        chk("t5_level", 32'(tif.level), 0);

        // Reset mid-drain discards contents and the sticky overflow at once.
        for (int i = 0; i < 5; i++) step_rand(1, 0, 0);
        chk("t6_level_pre", 32'(tif.level), 5);
        chk_en = 0;
        #2 reset = 0;
        #1;
        chk("t6_rst_valid", 32'(tif.out_valid), 0);
        chk("t6_rst_level", 32'(tif.level), 0);
        chk("t6_rst_ovf", 32'(tif.overflow), 0);
        exp_q.delete();
        m_cnt = 0; m_ovf = 0; exp_level = 0; exp_ovf = 0;
        set_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1;
        chk_en = 1;
        step(1, 32'h3040, 5'd31, 32'hcafef00d, 0, '0, '0, '0, 1);
        chk("t6_post_valid", 32'(tif.out_valid), 1);
        idle(1); idle(1); idle(1);
        chk("t6_sb_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
